// File: rtl/ahb_arb2_pkg.sv
// Shared AHB-Lite constants and the captured control bundle used by the
// two-master arbiter and its peripherals.
package ahb_arb2_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;

   localparam logic [2:0] HSIZE_BYTE    = 3'b000;
   localparam logic [2:0] HSIZE_HALF    = 3'b001;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;

   // Address-phase control that travels with a buffered transfer.
   typedef struct packed {
      logic       hwrite;
      logic [2:0] hsize;
      logic [2:0] hburst;
   } ahb_ctrl_t;

endpackage

// File: rtl/ahb_arb2_if.sv
// Bus bundle for the 2-master arbiter: both master ports (index 0 = core LSU,
// 1 = debug/DMA) plus the shared slave-side port. Suffixes are from the
// arbiter's point of view.
interface ahb_arb2_if #(
   parameter int AWIDTH = 32,
   parameter int DWIDTH = 32
);
   logic [1:0][1:0]        m_htrans_i;
   logic [1:0][AWIDTH-1:0] m_haddr_i;
   logic [1:0]             m_hwrite_i;
   logic [1:0][2:0]        m_hsize_i;
   logic [1:0][2:0]        m_hburst_i;
   logic [1:0][DWIDTH-1:0] m_hwdata_i;
   logic [1:0]             m_hready_o;
   logic [1:0]             m_hresp_o;
   logic [1:0][DWIDTH-1:0] m_hrdata_o;

   logic [1:0]             s_htrans_o;
   logic [AWIDTH-1:0]      s_haddr_o;
   logic                   s_hwrite_o;
   logic [2:0]             s_hsize_o;
   logic [2:0]             s_hburst_o;
   logic [DWIDTH-1:0]      s_hwdata_o;
   logic                   s_hready_i;
   logic                   s_hresp_i;
   logic [DWIDTH-1:0]      s_hrdata_i;
   logic [1:0]             grant_o;

   // The arbiter masters the shared slave-side bus.
   modport master (
      input  m_htrans_i, m_haddr_i, m_hwrite_i, m_hsize_i, m_hburst_i, m_hwdata_i,
      input  s_hready_i, s_hresp_i, s_hrdata_i,
      output m_hready_o, m_hresp_o, m_hrdata_o,
      output s_htrans_o, s_haddr_o, s_hwrite_o, s_hsize_o, s_hburst_o, s_hwdata_o,
      output grant_o
   );

   // Environment side: the two bus masters and the decoded slave.
   modport slave (
      output m_htrans_i, m_haddr_i, m_hwrite_i, m_hsize_i, m_hburst_i, m_hwdata_i,
      output s_hready_i, s_hresp_i, s_hrdata_i,
      input  m_hready_o, m_hresp_o, m_hrdata_o,
      input  s_htrans_o, s_haddr_o, s_hwrite_o, s_hsize_o, s_hburst_o, s_hwdata_o,
      input  grant_o
   );
endinterface

// File: rtl/ahb_arb2_pend.sv
// Per-master capture buffer: holds the address phase of a master that was
// told "ready" but could not be put on the slave bus that cycle.
module ahb_arb2_pend
   import ahb_arb2_pkg::*;
#(
   parameter int AWIDTH = 32
) (
   input  logic              hclk,
   input  logic              hresetn,
   input  logic              cap_i,
   input  logic              clr_i,
   input  logic [AWIDTH-1:0] haddr_i,
   input  ahb_ctrl_t         ctrl_i,
   output logic              pend_o,
   output logic [AWIDTH-1:0] haddr_o,
   output ahb_ctrl_t         ctrl_o
);
   logic              pend_q, pend_d;
   logic [AWIDTH-1:0] addr_q, addr_d;
   ahb_ctrl_t         ctrl_q, ctrl_d;

   // Capture on a lost live request, release once the slave accepts the copy.
   always_comb begin
      pend_d = pend_q;
      addr_d = addr_q;
      ctrl_d = ctrl_q;
      if (clr_i) pend_d = 1'b0;
      if (cap_i) begin
         pend_d = 1'b1;
         addr_d = haddr_i;
         ctrl_d = ctrl_i;
      end
   end

   // Buffer state; reset drops any pending transfer.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         pend_q <= 1'b0;
         addr_q <= '0;
         ctrl_q <= '0;
      end else begin
         pend_q <= pend_d;
         addr_q <= addr_d;
         ctrl_q <= ctrl_d;
      end
   end

   assign pend_o  = pend_q;
   assign haddr_o = addr_q;
   assign ctrl_o  = ctrl_q;
endmodule

// File: rtl/ahb_arb2.sv
// 2-master AHB-Lite arbiter in front of one slave-side port. Address phase
// is forwarded combinationally; a losing master is buffered and stalled.
// Define AHB_ARB_RR_EN for round-robin arbitration; default is fixed
// priority with M0 always winning.
module ahb_arb2
   import ahb_arb2_pkg::*;
#(
   parameter int AWIDTH = 32,
   parameter int DWIDTH = 32
) (
   input  logic       hclk,
   input  logic       hresetn,
   ahb_arb2_if.master bus
);
   logic [1:0]             hready, live_req, req, pend, cap, clr, grant;
   logic [1:0][AWIDTH-1:0] pend_addr;
   ahb_ctrl_t [1:0]        live_ctrl, pend_ctrl;
   logic                   win, sel, act, accept, busy_fwd;
   logic [1:0]             s_htrans;
   logic [AWIDTH-1:0]      s_haddr;
   ahb_ctrl_t              s_ctrl;
   logic                   dph_own_q, dph_own_d, dph_vld_q, dph_vld_d;
   logic                   prv_own_q, prv_own_d, prv_pend_q, prv_pend_d, prv_vld_q, prv_vld_d;

   // Per-master ready and live request; a request only counts when the
   // master sees ready, i.e. its address phase is really being offered.
   always_comb begin
      hready    = '0;
      live_req  = '0;
      live_ctrl = '0;
      for (int x = 0; x < 2; x++) begin
         if (pend[x])                                 hready[x] = 1'b0;
         else if (dph_vld_q && dph_own_q == 1'(x))    hready[x] = bus.s_hready_i;
         else                                         hready[x] = 1'b1;
         live_req[x]  = hresetn & bus.m_htrans_i[x][1] & hready[x];
         live_ctrl[x] = '{hwrite: bus.m_hwrite_i[x], hsize: bus.m_hsize_i[x],
                          hburst: bus.m_hburst_i[x]};
      end
   end

   assign req = live_req | pend;

`ifdef AHB_ARB_RR_EN
   logic rr_last_q, rr_last_d;

   // A lone pending master always wins so it is served in the next slot;
   // otherwise contention goes to whoever did not win the last contention.
   always_comb begin
      if (pend == 2'b01)      win = 1'b0;
      else if (pend == 2'b10) win = 1'b1;
      else if (req == 2'b11)  win = ~rr_last_q;
      else                    win = ~req[0];
   end

   // Remember the winner of each accepted contention.
   always_comb begin
      rr_last_d = rr_last_q;
      if (accept && req == 2'b11) rr_last_d = win;
   end

   // Round-robin history flop.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) rr_last_q <= 1'b0;
      else          rr_last_q <= rr_last_d;
   end
`else
   assign win = ~req[0];
`endif

   // BUSY is only passed through for the master that issued the previous
   // slave-side address phase (it is mid-burst); from anyone else it is idle.
   assign busy_fwd = ~|req & prv_vld_q & ~prv_pend_q & hready[prv_own_q] & hresetn
                     & (bus.m_htrans_i[prv_own_q] == HTRANS_BUSY);
   assign act      = |req | busy_fwd;
   assign sel      = (|req) ? win : prv_own_q;
   assign accept   = act & bus.s_hready_i;

   // Slave-side address mux: buffered copy restarts as NONSEQ, and a live
   // SEQ that does not continue the previous slave-side phase is re-based.
   always_comb begin
      s_htrans = HTRANS_IDLE;
      s_haddr  = '0;
      s_ctrl   = '0;
      grant    = '0;
      if (act) begin
         grant[sel] = 1'b1;
         if (pend[sel]) begin
            s_htrans = HTRANS_NONSEQ;
            s_haddr  = pend_addr[sel];
            s_ctrl   = pend_ctrl[sel];
         end else begin
            s_htrans = bus.m_htrans_i[sel];
            s_haddr  = bus.m_haddr_i[sel];
            s_ctrl   = live_ctrl[sel];
            if (s_htrans == HTRANS_SEQ && (!prv_vld_q || prv_pend_q || prv_own_q != sel))
               s_htrans = HTRANS_NONSEQ;
         end
      end
   end

   assign cap = live_req & ~(grant & {2{accept}});
   assign clr = pend & grant & {2{accept}};

   // Data-phase owner and previous address-phase source advance with the slave.
   always_comb begin
      dph_own_d  = dph_own_q;
      dph_vld_d  = dph_vld_q;
      prv_own_d  = prv_own_q;
      prv_pend_d = prv_pend_q;
      prv_vld_d  = prv_vld_q;
      if (bus.s_hready_i) begin
         dph_vld_d = act & s_htrans[1];
         dph_own_d = sel;
         if (act) begin
            prv_vld_d  = 1'b1;
            prv_own_d  = sel;
            prv_pend_d = pend[sel];
         end
      end
   end

   // Ownership registers.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         dph_own_q  <= 1'b0;
         dph_vld_q  <= 1'b0;
         prv_own_q  <= 1'b0;
         prv_pend_q <= 1'b0;
         prv_vld_q  <= 1'b0;
      end else begin
         dph_own_q  <= dph_own_d;
         dph_vld_q  <= dph_vld_d;
         prv_own_q  <= prv_own_d;
         prv_pend_q <= prv_pend_d;
         prv_vld_q  <= prv_vld_d;
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_m
      ahb_arb2_pend #(.AWIDTH(AWIDTH)) u_pend (
         .hclk    (hclk),
         .hresetn (hresetn),
         .cap_i   (cap[g]),
         .clr_i   (clr[g]),
         .haddr_i (bus.m_haddr_i[g]),
         .ctrl_i  (live_ctrl[g]),
         .pend_o  (pend[g]),
         .haddr_o (pend_addr[g]),
         .ctrl_o  (pend_ctrl[g])
      );
      assign bus.m_hresp_o[g]  = bus.s_hresp_i & dph_vld_q & (dph_own_q == 1'(g));
      assign bus.m_hrdata_o[g] = bus.s_hrdata_i;
   end

   assign bus.m_hready_o = hready;
   assign bus.s_htrans_o = s_htrans;
   assign bus.s_haddr_o  = s_haddr;
   assign bus.s_hwrite_o = s_ctrl.hwrite;
   assign bus.s_hsize_o  = s_ctrl.hsize;
   assign bus.s_hburst_o = s_ctrl.hburst;
   assign bus.s_hwdata_o = bus.m_hwdata_i[dph_own_q];
   assign bus.grant_o    = grant;
endmodule

// File: tb/tb_ahb_arb2.sv
// Directed bench for ahb_arb2 (fixed-priority build). Accepted slave-side
// address phases are checked against a queue of expected phases; stalls,
// data steering and reset behaviour are checked inline.
module tb_ahb_arb2;
   import ahb_arb2_pkg::*;

   typedef struct packed {
      logic [1:0]  grant;
      logic [1:0]  htrans;
      logic [31:0] addr;
      logic        hwrite;
   } aph_t;

   logic hclk    = 1'b0;
   logic hresetn = 1'b0;
   int   checks  = 0;
   int   errors  = 0;
   aph_t exp_q[$];
   aph_t mon_got, mon_exp;

   ahb_arb2_if #(.AWIDTH(32), .DWIDTH(32)) bus ();
   ahb_arb2 #(.AWIDTH(32), .DWIDTH(32)) dut (.hclk(hclk), .hresetn(hresetn), .bus(bus));

   always #5 hclk = ~hclk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge hclk);
      #1;
   endtask

   task automatic smp();
      @(negedge hclk);
   endtask

   task automatic m_drv(input int x, input logic [1:0] t, input logic [31:0] a,
                        input logic w, input logic [2:0] b);
      bus.m_htrans_i[x] = t;
      bus.m_haddr_i[x]  = a;
      bus.m_hwrite_i[x] = w;
      bus.m_hburst_i[x] = b;
   endtask

   task automatic push(input logic [1:0] g, input logic [1:0] t, input logic [31:0] a,
                       input logic w);
      exp_q.push_back('{grant: g, htrans: t, addr: a, hwrite: w});
   endtask

   // Every address phase the slave accepts must be the next one expected.
   always @(negedge hclk) begin
      if (hresetn && bus.s_hready_i && bus.s_htrans_o[1]) begin
         mon_got = '{grant: bus.grant_o, htrans: bus.s_htrans_o,
                     addr: bus.s_haddr_o, hwrite: bus.s_hwrite_o};
         if (exp_q.size() == 0) chk("aph_extra", 64'(mon_got), 64'(0));
         else begin
            mon_exp = exp_q.pop_front();
            chk("aph", 64'(mon_got), 64'(mon_exp));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.m_htrans_i = '0;
      bus.m_haddr_i  = '0;
      bus.m_hwrite_i = '0;
      bus.m_hsize_i  = {HSIZE_WORD, HSIZE_WORD};
      bus.m_hburst_i = '0;
      bus.m_hwdata_i = '0;
      bus.s_hready_i = 1'b1;
      bus.s_hresp_i  = 1'b0;
      bus.s_hrdata_i = '0;

      // reset state
      smp();
      chk("rst_htrans", bus.s_htrans_o, HTRANS_IDLE);
      chk("rst_haddr",  bus.s_haddr_o, 0);
      chk("rst_grant",  bus.grant_o, 2'b00);
      chk("rst_hready", bus.m_hready_o, 2'b11);
      chk("rst_hresp",  bus.m_hresp_o, 2'b00);
      hresetn = 1'b1;

      // 1: uncontended M0 write, slave adds one wait state
      cyc();
      m_drv(0, HTRANS_NONSEQ, 32'h0200_0008, 1'b1, HBURST_SINGLE);
      push(2'b01, HTRANS_NONSEQ, 32'h0200_0008, 1'b1);
      smp();
      chk("t1_haddr",  bus.s_haddr_o, 32'h0200_0008);
      chk("t1_hsize",  bus.s_hsize_o, HSIZE_WORD);
      chk("t1_grant",  bus.grant_o, 2'b01);
      chk("t1_hready", bus.m_hready_o[0], 1'b1);
      cyc();
      m_drv(0, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE);
      bus.m_hwdata_i[0] = 32'h0000_0064;
      bus.s_hready_i    = 1'b0;
      smp();
      chk("t1_wait_hready0", bus.m_hready_o[0], 1'b0);
      chk("t1_idle_hready1", bus.m_hready_o[1], 1'b1);
      chk("t1_hwdata",       bus.s_hwdata_o, 32'h0000_0064);
      cyc();
      bus.s_hready_i = 1'b1;
      smp();
      chk("t1_done_hready0", bus.m_hready_o[0], 1'b1);
      chk("t1_hwdata_hold",  bus.s_hwdata_o, 32'h0000_0064);

      // 2: simultaneous reads, M0 first, M1 buffered; 6: error to M1 only
      cyc();
      m_drv(0, HTRANS_NONSEQ, 32'h0200_0000, 1'b0, HBURST_SINGLE);
      m_drv(1, HTRANS_NONSEQ, 32'h0200_0004, 1'b0, HBURST_SINGLE);
      push(2'b01, HTRANS_NONSEQ, 32'h0200_0000, 1'b0);
      push(2'b10, HTRANS_NONSEQ, 32'h0200_0004, 1'b0);
      smp();
      chk("t2_grant_m0",    bus.grant_o, 2'b01);
      chk("t2_m1_hready_a", bus.m_hready_o[1], 1'b1);
      cyc();
      m_drv(0, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE);
      m_drv(1, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE);
      bus.s_hrdata_i = 32'hAAAA_0000;
      smp();
      chk("t2_m1_stall",  bus.m_hready_o[1], 1'b0);
      chk("t2_m0_hready", bus.m_hready_o[0], 1'b1);
      chk("t2_grant_m1",  bus.grant_o, 2'b10);
      chk("t2_haddr_pnd", bus.s_haddr_o, 32'h0200_0004);
      chk("t2_m0_rdata",  bus.m_hrdata_o[0], 32'hAAAA_0000);
      cyc();
      bus.s_hrdata_i = 32'hBBBB_0004;
      bus.s_hresp_i  = 1'b1;
      smp();
      chk("t2_m1_hready", bus.m_hready_o[1], 1'b1);
      chk("t2_m1_rdata",  bus.m_hrdata_o[1], 32'hBBBB_0004);
      chk("t2_idle",      bus.s_htrans_o, HTRANS_IDLE);
      chk("t6_m1_hresp",  bus.m_hresp_o[1], 1'b1);
      chk("t6_m0_hresp",  bus.m_hresp_o[0], 1'b0);

      // 3: two wait states on M0 read while M1 requests
      cyc();
      bus.s_hresp_i = 1'b0;
      m_drv(0, HTRANS_NONSEQ, 32'h0200_0010, 1'b0, HBURST_SINGLE);
      push(2'b01, HTRANS_NONSEQ, 32'h0200_0010, 1'b0);
      smp();
      chk("t3_grant_m0", bus.grant_o, 2'b01);
      cyc();
      m_drv(0, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE);
      m_drv(1, HTRANS_NONSEQ, 32'h0200_0014, 1'b1, HBURST_SINGLE);
      push(2'b10, HTRANS_NONSEQ, 32'h0200_0014, 1'b1);
      bus.s_hready_i = 1'b0;
      smp();
      chk("t3_m0_wait",  bus.m_hready_o[0], 1'b0);
      chk("t3_m1_live",  bus.m_hready_o[1], 1'b1);
      chk("t3_haddr_w1", bus.s_haddr_o, 32'h0200_0014);
      cyc();
      m_drv(1, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE);
      bus.m_hwdata_i[1] = 32'h0000_0055;
      smp();
      chk("t3_m1_stall", bus.m_hready_o[1], 1'b0);
      chk("t3_haddr_w2", bus.s_haddr_o, 32'h0200_0014);
      chk("t3_grant_w2", bus.grant_o, 2'b10);
      cyc();
      bus.s_hready_i = 1'b1;
      bus.s_hrdata_i = 32'hCCCC_0010;
      smp();
      chk("t3_m0_done",  bus.m_hready_o[0], 1'b1);
      chk("t3_m0_rdata", bus.m_hrdata_o[0], 32'hCCCC_0010);
      chk("t3_m1_hold",  bus.m_hready_o[1], 1'b0);
      cyc();
      smp();
      chk("t3_m1_done",   bus.m_hready_o[1], 1'b1);
      chk("t3_m1_hwdata", bus.s_hwdata_o, 32'h0000_0055);

      // 4: M1 INCR4 interleaved by M0, resumed beats restart as NONSEQ
      cyc();
      m_drv(1, HTRANS_NONSEQ, 32'h0200_0100, 1'b1, HBURST_INCR4);
      push(2'b10, HTRANS_NONSEQ, 32'h0200_0100, 1'b1);
      cyc();
      m_drv(1, HTRANS_SEQ, 32'h0200_0104, 1'b1, HBURST_INCR4);
      push(2'b10, HTRANS_SEQ, 32'h0200_0104, 1'b1);
      smp();
      chk("t4_seq_kept", bus.s_htrans_o, HTRANS_SEQ);
      cyc();
      m_drv(1, HTRANS_SEQ, 32'h0200_0108, 1'b1, HBURST_INCR4);
      m_drv(0, HTRANS_NONSEQ, 32'h0200_0020, 1'b0, HBURST_SINGLE);
      push(2'b01, HTRANS_NONSEQ, 32'h0200_0020, 1'b0);
      push(2'b10, HTRANS_NONSEQ, 32'h0200_0108, 1'b1);
      smp();
      chk("t4_grant_m0", bus.grant_o, 2'b01);
      cyc();
      m_drv(0, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE);
      m_drv(1, HTRANS_SEQ, 32'h0200_010C, 1'b1, HBURST_INCR4);
      smp();
      chk("t4_resume_htrans", bus.s_htrans_o, HTRANS_NONSEQ);
      chk("t4_resume_haddr",  bus.s_haddr_o, 32'h0200_0108);
      chk("t4_m1_stall",      bus.m_hready_o[1], 1'b0);
      cyc();
      push(2'b10, HTRANS_NONSEQ, 32'h0200_010C, 1'b1);
      smp();
      chk("t4_next_htrans", bus.s_htrans_o, HTRANS_NONSEQ);
      chk("t4_next_haddr",  bus.s_haddr_o, 32'h0200_010C);
      cyc();
      m_drv(1, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE);

      // 5: reset asserted while M1 is pending
      cyc();
      m_drv(0, HTRANS_NONSEQ, 32'h0200_0030, 1'b0, HBURST_SINGLE);
      m_drv(1, HTRANS_NONSEQ, 32'h0200_0034, 1'b0, HBURST_SINGLE);
      push(2'b01, HTRANS_NONSEQ, 32'h0200_0030, 1'b0);
      smp();
      chk("t5_grant_m0", bus.grant_o, 2'b01);
      cyc();
      m_drv(0, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE);
      m_drv(1, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE);
      bus.s_hready_i = 1'b0;
      smp();
      chk("t5_m1_pend",  bus.m_hready_o[1], 1'b0);
      chk("t5_grant_m1", bus.grant_o, 2'b10);
      #2;
      hresetn = 1'b0;
      m_drv(0, HTRANS_NONSEQ, 32'h0200_0038, 1'b0, HBURST_SINGLE);
      #1;
      chk("t5_rst_hready1", bus.m_hready_o[1], 1'b1);
      chk("t5_rst_hready0", bus.m_hready_o[0], 1'b1);
      chk("t5_rst_htrans",  bus.s_htrans_o, HTRANS_IDLE);
      chk("t5_rst_grant",   bus.grant_o, 2'b00);
      smp();
      m_drv(0, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE);
      bus.s_hready_i = 1'b1;
      hresetn        = 1'b1;
      cyc();
      cyc();
      smp();
      chk("t5_no_replay",   bus.s_htrans_o, HTRANS_IDLE);
      chk("t5_m1_released", bus.m_hready_o[1], 1'b1);

      chk("sb_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
